// File: rtl/jt6295_adpcm_dec.sv
// Four-channel time-multiplexed OKI ADPCM decoder, two-stage pipeline per slot.
// Optional output attenuation is enabled with `define JT6295_ATT_EN.
module jt6295_adpcm_dec (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               cen4,
    output logic [1:0]         slot,
    input  logic [3:0]         din,
    input  logic [3:0]         start,
    input  logic [3:0]         chon,
`ifdef JT6295_ATT_EN
    input  logic [15:0]        att,
`endif
    output logic signed [11:0] sound
);

    logic signed [11:0] sig_mem [4];
    logic [5:0]         idx_mem [4];

    logic [1:0]         ch_cur;
    logic signed [11:0] sig_rd;
    logic [5:0]         idx_rd;

    logic               v1;
    logic [1:0]         ch1;
    logic [3:0]         din1;
    logic               start1;
    logic               chon1;
    logic signed [11:0] sig1;
    logic [5:0]         idx1;
    logic [10:0]        st1;
`ifdef JT6295_ATT_EN
    logic [3:0]         att1;
`endif

    logic [12:0]        st_w;
    logic [12:0]        diff;
    logic signed [13:0] s_sum;
    logic signed [11:0] s_new;
    logic signed [6:0]  adj;
    logic signed [6:0]  i_sum;
    logic [5:0]         i_new;
    logic signed [11:0] s_out;

    function automatic logic [10:0] step_lut(input logic [5:0] n);
        case (n)
            6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;
            6'd2:  step_lut = 11'd19;   6'd3:  step_lut = 11'd21;
            6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
            6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;
            6'd8:  step_lut = 11'd34;   6'd9:  step_lut = 11'd37;
            6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
            6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;
            6'd14: step_lut = 11'd60;   6'd15: step_lut = 11'd66;
            6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
            6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;
            6'd20: step_lut = 11'd107;  6'd21: step_lut = 11'd118;
            6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
            6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;
            6'd26: step_lut = 11'd190;  6'd27: step_lut = 11'd209;
            6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
            6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;
            6'd32: step_lut = 11'd337;  6'd33: step_lut = 11'd371;
            6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
            6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;
            6'd38: step_lut = 11'd598;  6'd39: step_lut = 11'd658;
            6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
            6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;
            6'd44: step_lut = 11'd1060; 6'd45: step_lut = 11'd1166;
            6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
            6'd48: step_lut = 11'd1552;
            default: step_lut = 11'd16;
        endcase
    endfunction

`ifdef JT6295_ATT_EN
    function automatic logic [5:0] gain_lut(input logic [3:0] a);
        case (a)
            4'd0: gain_lut = 6'd32;
            4'd1: gain_lut = 6'd22;
            4'd2: gain_lut = 6'd16;
            4'd3: gain_lut = 6'd11;
            4'd4: gain_lut = 6'd8;
            4'd5: gain_lut = 6'd6;
            4'd6: gain_lut = 6'd4;
            4'd7: gain_lut = 6'd3;
            4'd8: gain_lut = 6'd2;
            default: gain_lut = 6'd0;
        endcase
    endfunction

    logic signed [18:0] prod;
`endif

    // The slot consumed at a frame strobe is forced to channel 0.
    assign ch_cur = cen ? 2'd0 : slot;

    always_comb begin
        sig_rd = sig_mem[ch_cur];
        idx_rd = idx_mem[ch_cur];
        if (start[ch_cur]) begin
            sig_rd = '0;
            idx_rd = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot   <= 2'd0;
            v1     <= 1'b0;
            ch1    <= 2'd0;
            din1   <= 4'd0;
            start1 <= 1'b0;
            chon1  <= 1'b0;
            sig1   <= '0;
            idx1   <= 6'd0;
            st1    <= 11'd0;
`ifdef JT6295_ATT_EN
            att1   <= 4'd0;
`endif
        end else begin
            v1 <= cen4;
            if (cen4) begin
                slot   <= cen ? 2'd1 : slot + 2'd1;
                ch1    <= ch_cur;
                din1   <= din;
                start1 <= start[ch_cur];
                chon1  <= chon[ch_cur];
                sig1   <= sig_rd;
                idx1   <= idx_rd;
                st1    <= step_lut(idx_rd);
`ifdef JT6295_ATT_EN
                att1   <= att[ch_cur*4 +: 4];
`endif
            end
        end
    end

    always_comb begin
        st_w = {2'b00, st1};
        diff = (st_w >> 3)
             + (din1[0] ? (st_w >> 2) : 13'd0)
             + (din1[1] ? (st_w >> 1) : 13'd0)
             + (din1[2] ? st_w        : 13'd0);

        s_sum = din1[3] ? (14'(sig1) - $signed({1'b0, diff}))
                        : (14'(sig1) + $signed({1'b0, diff}));
        if (s_sum > 14'sd2047)
            s_new = 12'sd2047;
        else if (s_sum < -14'sd2048)
            s_new = -12'sd2048;
        else
            s_new = s_sum[11:0];

        case (din1[2:0])
            3'd4:    adj = 7'sd2;
            3'd5:    adj = 7'sd4;
            3'd6:    adj = 7'sd6;
            3'd7:    adj = 7'sd8;
            default: adj = -7'sd1;
        endcase
        i_sum = $signed({1'b0, idx1}) + adj;
        if (i_sum < 7'sd0)
            i_new = 6'd0;
        else if (i_sum > 7'sd48)
            i_new = 6'd48;
        else
            i_new = i_sum[5:0];
    end

`ifdef JT6295_ATT_EN
    // Arithmetic shift of the product floors toward minus infinity.
    assign prod  = 19'(s_new) * 19'($signed({1'b0, gain_lut(att1)}));
    assign s_out = prod[16:5];
`else
    assign s_out = s_new;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sound <= '0;
            for (int k = 0; k < 4; k++) begin
                sig_mem[k] <= '0;
                idx_mem[k] <= 6'd0;
            end
        end else if (v1) begin
            if (chon1) begin
                sig_mem[ch1] <= s_new;
                idx_mem[ch1] <= i_new;
                sound        <= s_out;
            end else begin
                sound <= '0;
                if (start1) begin
                    sig_mem[ch1] <= '0;
                    idx_mem[ch1] <= 6'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt6295_adpcm_dec.sv
// Randomised bench for jt6295_adpcm_dec against an arithmetic OKI ADPCM model.
// Attenuation stimulus is applied only when JT6295_ATT_EN is defined.
module tb_jt6295_adpcm_dec;

    logic               clk;
    logic               rst;
    logic               cen;
    logic               cen4;
    logic [1:0]         slot;
    logic [3:0]         din;
    logic [3:0]         start;
    logic [3:0]         chon;
    logic [15:0]        att;
    logic signed [11:0] sound;

    int n_tests;
    int n_fail;
    int step_tab [49];
    int adj_tab  [8];
    int gain_tab [16];
    int m_sig [4];
    int m_idx [4];
    int tb_slot;

    jt6295_adpcm_dec dut (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .cen4  (cen4),
        .slot  (slot),
        .din   (din),
        .start (start),
        .chon  (chon),
`ifdef JT6295_ATT_EN
        .att   (att),
`endif
        .sound (sound)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_sig[k] = 0;
            m_idx[k] = 0;
        end
        tb_slot = 0;
    endtask

    // Reference decode from plain integer arithmetic; returns the expected output.
    task automatic model_decode(input int ch, input int d, input bit st, input bit on,
                                input int a, output int res);
        int s, i, stp, dif, sn, inx, p, g;
        s   = st ? 0 : m_sig[ch];
        i   = st ? 0 : m_idx[ch];
        stp = step_tab[i];
        dif = stp / 8;
        if (d & 1) dif += stp / 4;
        if (d & 2) dif += stp / 2;
        if (d & 4) dif += stp;
        sn  = (d & 8) ? s - dif : s + dif;
        if (sn > 2047)  sn = 2047;
        if (sn < -2048) sn = -2048;
        inx = i + adj_tab[d & 7];
        if (inx < 0)  inx = 0;
        if (inx > 48) inx = 48;
        res = 0;
        if (on) begin
            m_sig[ch] = sn;
            m_idx[ch] = inx;
`ifdef JT6295_ATT_EN
            g = gain_tab[a];
`else
            g = 32;
`endif
            p = sn * g;
            res = (p >= 0) ? p / 32 : -((-p + 31) / 32);
        end else if (st) begin
            m_sig[ch] = 0;
            m_idx[ch] = 0;
        end
    endtask

    task automatic run_slot(input bit c, input logic [3:0] d, input logic [3:0] st,
                            input logic [3:0] on, input logic [15:0] a);
        int ch, exp;
        chk("slot", int'(slot), tb_slot);
        ch = c ? 0 : tb_slot;
        cen = c; cen4 = 1'b1; din = d; start = st; chon = on; att = a;
        @(posedge clk); #1;
        cen = 1'b0; cen4 = 1'b0; din = 4'($urandom); start = 4'd0;
        chon = 4'($urandom); att = 16'($urandom);
        model_decode(ch, int'(d), st[ch], on[ch], int'(a[ch*4 +: 4]), exp);
        tb_slot = c ? 1 : (tb_slot + 1) % 4;
        @(posedge clk); #1;
        chk("sound", int'(sound), exp);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input logic [15:0] d, input logic [3:0] st,
                             input logic [3:0] on, input logic [15:0] a);
        for (int k = 0; k < 4; k++)
            run_slot(k == 0, d[k*4 +: 4], st, on, a);
    endtask

    initial begin
        real v;
        int  frozen_sig, frozen_idx;
        logic [15:0] rd, ra;
        logic [3:0]  rs, ron;

        n_tests = 0; n_fail = 0;
        v = 16.0;
        for (int n = 0; n < 49; n++) begin
            step_tab[n] = $rtoi(v);
            v = v * 1.1;
        end
        for (int k = 0; k < 8; k++) adj_tab[k] = (k < 4) ? -1 : 2 * (k - 3);
        gain_tab = '{32, 22, 16, 11, 8, 6, 4, 3, 2, 0, 0, 0, 0, 0, 0, 0};
        model_reset();

        rst = 1'b1; cen = 1'b0; cen4 = 1'b0; din = 4'd0; start = 4'd0;
        chon = 4'd0; att = 16'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_sound", int'(sound), 0);
        chk("rst_slot", int'(slot), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(16'h0000, 4'b0000, 4'b0001, 16'h0000);
        chk("idx0_first", int'(dut.idx_mem[0]), m_idx[0]);
        chk("sig0_first", int'(dut.sig_mem[0]), 2);

        run_slot(1'b1, 4'h7, 4'b0001, 4'b0001, 16'h0000);
        chk("start_sig0", int'(sound), 30);
        chk("start_idx0", int'(dut.idx_mem[0]), 8);
        run_slot(1'b0, 4'h0, 4'b0000, 4'b0000, 16'h0000);
        run_slot(1'b0, 4'h0, 4'b0000, 4'b0000, 16'h0000);
        run_slot(1'b0, 4'h0, 4'b0000, 4'b0000, 16'h0000);
        run_slot(1'b1, 4'hF, 4'b0000, 4'b0001, 16'h0000);
        chk("neg_sig0", int'(sound), -33);
        chk("neg_idx0", int'(dut.idx_mem[0]), 16);
        run_slot(1'b0, 4'h0, 4'b0000, 4'b0000, 16'h0000);
        run_slot(1'b0, 4'h0, 4'b0000, 4'b0000, 16'h0000);
        run_slot(1'b0, 4'h0, 4'b0000, 4'b0000, 16'h0000);

        run_frame(16'h0070, 4'b0010, 4'b0010, 16'h0000);
        repeat (11) run_frame(16'h0070, 4'b0000, 4'b0010, 16'h0000);
        chk("sat_hi_sig", int'(dut.sig_mem[1]), 2047);
        chk("sat_hi_idx", int'(dut.idx_mem[1]), 48);
        repeat (4) run_frame(16'h00F0, 4'b0000, 4'b0010, 16'h0000);
        chk("sat_lo_sig", int'(dut.sig_mem[1]), -2048);

        run_frame(16'h3456, 4'b0000, 4'b1111, 16'h0000);
        frozen_sig = m_sig[2];
        frozen_idx = m_idx[2];
        repeat (3) run_frame(16'($urandom), 4'b0000, 4'b1011, 16'h0000);
        chk("frz_sig2", int'(dut.sig_mem[2]), frozen_sig);
        chk("frz_idx2", int'(dut.idx_mem[2]), frozen_idx);
        run_frame(16'h7777, 4'b0000, 4'b1111, 16'h0000);

        for (int f = 0; f < 300; f++) begin
            rd  = 16'($urandom);
            rs  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            ron = 4'($urandom) | 4'($urandom) | 4'($urandom);
`ifdef JT6295_ATT_EN
            ra = 16'($urandom);
`else
            ra = 16'h0000;
`endif
            run_frame(rd, rs, ron, ra);
        end
        for (int k = 0; k < 4; k++) begin
            chk("end_sig", int'(dut.sig_mem[k]), m_sig[k]);
            chk("end_idx", int'(dut.idx_mem[k]), m_idx[k]);
        end

        cen = 1'b1; cen4 = 1'b1; din = 4'h7; start = 4'b0001; chon = 4'b0001;
        @(posedge clk); #1;
        cen = 1'b0; cen4 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_sound", int'(sound), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("midrst_sig0", int'(dut.sig_mem[0]), 0);
        chk("midrst_slot", int'(slot), 0);
        repeat (5) run_frame(16'($urandom), 4'b0000, 4'b1111, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jt6295_adpcm_dec.md
# jt6295_adpcm_dec

Four-channel, time-multiplexed OKI ADPCM decoder for the JT6295 sound path. It converts one 4-bit ADPCM nibble per channel slot into a 12-bit signed sample and holds per-channel predictor state. Its output feeds the downstream accumulator/interpolator, which sums the four slot values presented on consecutive `cen4` strobes into one output sample per `cen`.

## Interface

Parameters:
- none

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `cen` in 1: sample strobe, one per four `cen4`. Coincides with a `cen4`.
- `cen4` in 1: channel-slot strobe. Consecutive strobes are at least 3 `clk` apart.
- `slot` out 2: channel whose nibble is consumed on the next `cen4`. Upstream nibble fetch uses it.
- `din` in 4: ADPCM nibble for `slot`, sampled on `cen4`. Bit 3 is the sign; bits 2:0 are magnitude.
- `start` in 4: per-channel restart. Bit `slot` is sampled on `cen4`.
- `chon` in 4: per-channel enable. Bit `slot` is sampled on `cen4`.
- `att` in 4×4 (16): per-channel attenuation. Present only with `JT6295_ATT_EN`.
- `sound` out 12 signed: decoded slot sample. Feeds the accumulator's `sound_in`.

## Operation

- Slot counter `slot`:
  - Increments (mod 4) on each `cen4`.
  - When `cen` and `cen4` are both high, the next `slot` is 1. This means the slot consumed at `cen` is always 0.
- Per-channel state:
  - `sig[ch]` is 12-bit signed.
  - `idx[ch]` is 6-bit, range 0..48.
  - Both are held in small register arrays.
- Step table: 49 entries, `step[n] = floor(16·1.1^n)`, giving 16, 17, 19, 21, 23, 25, 28, 31, 34, … 1552. Implemented as a ROM.
- Decode for the consumed slot `ch`:
  - If `start[ch]` is high, decode from `s=0, i=0`. Otherwise decode from `s=sig[ch], i=idx[ch]`.
  - `st = step[i]`.
  - `diff = st>>3 + (din[0]? st>>2) + (din[1]? st>>1) + (din[2]? st)`, computed in 13-bit unsigned.
  - `s' = din[3] ? s−diff : s+diff`, computed in 14-bit, then saturated to the range −2048..2047.
  - `i' = i + adj[din[2:0]]`, where `adj` = {−1, −1, −1, −1, +2, +4, +6, +8}, clamped to 0..48.
- Channel enabled (`chon[ch]=1`): write back `sig[ch]=s'` and `idx[ch]=i'`; `sound = s'`.
- Channel disabled (`chon[ch]=0`):
  - `sound = 0`.
  - State is not updated, except that `start` still clears `sig` and `idx` to 0.
- Simultaneous `start` and `chon`: the channel restarts and its first nibble is decoded from zero state in the same slot.

## Timing

- Pipeline has two stages:
  - Stage 1, on `clk` with `cen4`: latch `ch`, `din`, `start`, `chon`, the `sig`/`idx` read and `st`.
  - Stage 2, next `clk`: compute `diff` and `s'`, write back state, register `sound`.
- `sound` is valid 2 `clk` after the `cen4` that consumed the nibble. It holds until the next slot's update, so it is stable at the following `cen4`.
- Reset values:
  - `sound=0`.
  - `slot=0`.
  - All `sig=0` and all `idx=0`.
  - Pipeline valid cleared.
- Reset mid-pipeline discards the in-flight slot: no write-back happens and `sound` stays 0.
- `cen4` spacing below 3 `clk` is unsupported.

## Configuration

- Macro `JT6295_ATT_EN`.
  - Defined:
    - The `att` port exists.
    - Stage 2 computes `sound = (s'·g[att[ch]])>>>5`, signed, truncated toward −∞.
    - `g` = {32, 22, 16, 11, 8, 6, 4, 3, 2} for `att` 0..8; `g=0` for `att`≥9.
    - Only the output is scaled; predictor state stores the unscaled `s'`.
    - Latency is unchanged.
  - Undefined: the port is absent and `sound = s'`.

## Test plan

- **Reset:** hold `rst` for 4 `clk` → `sound=0` and `slot=0`; after release, a first nibble `0x0` on channel 0 with `chon=1` → `sound=2` and `idx[0]=0`.
- **Start sequence on channel 0:** `start=1`, `din=0x7` → `sound=30`, `idx=8`. Next channel-0 slot, `din=0xF` → `sound=−33` (diff 63), `idx=16`.
- **Saturation:** repeated `din=0x7` on channel 1 → `sound` climbs, then stays at 2047 and `idx` stays 48. Repeated `0xF` → reaches −2048.
- **Multiplexing:** four channels with distinct nibbles → `slot` sequence 0,1,2,3 aligned to `cen`; each `sound` matches the golden per-channel model at `cen4`+2.
- **Disable:** `chon[2]=0` for 3 frames → `sound=0` in slot 2 and channel-2 state is frozen. Re-enable → decoding resumes from the held `sig`/`idx`.
- **Attenuation (`JT6295_ATT_EN` defined):** `s'=1000`, `att=2` → `sound=500`; `att=9` → `sound=0`; the next nibble is decoded from `sig=1000`.
